// File: rtl/cla_pkg.sv
// Shared constants for the digit-serial carry-lookahead adder.
package cla_pkg;

   localparam int DIGIT_W = 4;

   // FSM encodings; 2'b11 is unused and recovers to idle
   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   // Digit counter width: clog2 of the digit count, never below 1 bit
   function automatic int cnt_w(input int ndig);
      int w;
      w = $clog2(ndig);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/cla4_slice.sv
// One 4-bit carry-lookahead slice, purely combinational.
module cla4_slice
   import cla_pkg::*;
(
   input  logic [DIGIT_W-1:0] x,
   input  logic [DIGIT_W-1:0] y,
   input  logic               ci,
   output logic [DIGIT_W-1:0] s,
   output logic               c3,
   output logic               c4
);

   logic [3:0] p;
   logic [3:0] g;
   logic       c1;
   logic       c2;

   // Propagate/generate, then every carry as a flat sum of products
   always_comb begin
      p  = x ^ y;
      g  = x & y;
      c1 = g[0] | (p[0] & ci);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
      s  = p ^ {c3, c2, c1, ci};
   end

endmodule

// File: rtl/cla_digit_serial_adder.sv
// Digit-serial add/subtract: one 4-bit lookahead slice reused over
// WIDTH/4 clocks, LSB digit first, valid/ready on both sides.
module cla_digit_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NDIG = WIDTH / DIGIT_W;
   localparam int CW   = cnt_w(NDIG);

   if ((WIDTH % DIGIT_W) != 0 || WIDTH < DIGIT_W) begin : g_bad_width
      $error("cla_digit_serial_adder: WIDTH must be a positive multiple of 4");
   end

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [DIGIT_W-1:0]       dig_s;
   logic                     dig_c3;
   logic                     dig_c4;
   logic [WIDTH+DIGIT_W-1:0] sum_ext;

   cla4_slice u_slice (
      .x  (opa_q[DIGIT_W-1:0]),
      .y  (opb_q[DIGIT_W-1:0]),
      .ci (carry_q),
      .s  (dig_s),
      .c3 (dig_c3),
      .c4 (dig_c4)
   );

   // Next-state: accept in idle, one digit per clock in run, hold in done
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      // new digit enters at the MSB end so the last digit lands correctly
      sum_ext = {dig_s, sum_q};
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               opa_d   = a;
               opb_d   = sub ? ~b : b;
               carry_d = sub;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d   = sum_ext[WIDTH+DIGIT_W-1:DIGIT_W];
            opa_d   = opa_q >> DIGIT_W;
            opb_d   = opb_q >> DIGIT_W;
            carry_d = dig_c4;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(NDIG - 1)) begin
               cout_d  = dig_c4;
               ovf_d   = dig_c3 ^ dig_c4;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any operation in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign sum       = sum_q;
   assign cout      = cout_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_digit_serial_adder.sv
// Bench for the digit-serial adder: directed corner cases plus random
// operations against an integer-arithmetic reference.
module tb_cla_digit_serial_adder;

   localparam int W    = 16;
   localparam int NDIG = W / 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int tests = 0;
   int fails = 0;

   cla_digit_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                        output logic [W-1:0] es, output logic ec, output logic eo);
      longint ua, ub, sa, sb, r, sr;
      ua = longint'(ma);
      ub = longint'(mb);
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      if (ms) begin
         r  = ua - ub;
         ec = (ua >= ub);
         sr = sa - sb;
      end else begin
         r  = ua + ub;
         ec = (r >= 65536);
         sr = sa + sb;
      end
      es = W'(r & 64'hFFFF);
      eo = (sr > 32767) || (sr < -32768);
   endtask

   // Issue one request, check latency and result, then drain it
   task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic ts);
      logic [W-1:0] es;
      logic         ec, eo;
      int           n;
      model(ta, tb_, ts, es, ec, eo);
      @(negedge clk);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      a = ta; b = tb_; sub = ts; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      n = 0;
      while (!out_valid && n < 3 * NDIG) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({tag, ".latency"}, 32'(n), 32'(NDIG));
      check({tag, ".sum"}, 32'(sum), 32'(es));
      check({tag, ".cout"}, 32'(cout), 32'(ec));
      check({tag, ".ovf"}, 32'(ovf), 32'(eo));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, ".drain_ov"}, 32'(out_valid), 32'd0);
      check({tag, ".drain_ir"}, 32'(in_ready), 32'd1);
   endtask

   initial begin
      logic [W-1:0] hold_sum;
      logic         hold_c, hold_o;
      int           n;

      #2;
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.sum", 32'(sum), 32'd0);
      check("reset.cout", 32'(cout), 32'd0);
      check("reset.ovf", 32'(ovf), 32'd0);
      #20;
      rst_n = 1'b1;

      // Directed corner cases
      run_op("add_5555", 16'h1234, 16'h4321, 1'b0);
      run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
      run_op("sovf", 16'h7FFF, 16'h0001, 1'b0);
      run_op("sub_neg", 16'h0005, 16'h0007, 1'b1);
      run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
      run_op("sub_eq", 16'hABCD, 16'hABCD, 1'b1);
      check("fixed.sum_sub_eq", 32'(sum), 32'h0);

      // Backpressure: result held, new requests ignored
      @(negedge clk);
      a = 16'h00F0; b = 16'h0F00; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 3 * NDIG) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("bp.latency", 32'(n), 32'(NDIG));
      hold_sum = sum; hold_c = cout; hold_o = ovf;
      check("bp.sum", 32'(hold_sum), 32'h0FF0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'(i & 1);
         a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
         check("bp.in_ready", 32'(in_ready), 32'd0);
         check("bp.out_valid", 32'(out_valid), 32'd1);
         check("bp.sum_hold", 32'(sum), 32'(hold_sum));
         check("bp.flags_hold", 32'({cout, ovf}), 32'({hold_c, hold_o}));
      end
      @(negedge clk);
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp.release_ov", 32'(out_valid), 32'd0);
      check("bp.release_ir", 32'(in_ready), 32'd1);
      check("bp.idle_sum_kept", 32'(sum), 32'h0FF0);
      @(posedge clk);
      #1;
      check("bp.stays_idle", 32'(in_ready), 32'd1);

      // Reset two edges into a run
      @(negedge clk);
      a = 16'h0000; b = 16'h0001; sub = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst.mid_running", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.sum", 32'(sum), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      run_op("post_rst", 16'h0001, 16'h0001, 1'b0);
      check("post_rst.sum2", 32'(sum), 32'h2);

      // Random operations
      for (int i = 0; i < 40; i++) begin
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // Global time bound so a stuck design still ends the run
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
